fx_vibrato_lfo: RTL and testbench
=================================

FX_VIBRATO_LFO -- requirements
Module: fx_vibrato_lfo

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent vibrato channels.
REQ-002 SHALL have parameter PHASE_W, default 5: per-channel phase width; one full LFO cycle is 2^PHASE_W steps.
REQ-003 SHALL have parameter MUL_W, default 3: offset_mul width per channel; PHASE_W-2 >= MUL_W is required.
REQ-004 SHALL have parameter DIV_W, default 4: speed/prescaler width per channel.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk50mhz input 1 system clock; rst_n input 1 async active-low reset.
REQ-006 SHALL have port note_tick, input, 1 bit: step strobe, one clk50mhz cycle wide, synchronous to clk50mhz.
REQ-007 SHALL have port en, input, NUM_CH bits: per-channel enable.
REQ-008 SHALL have port trig, input, NUM_CH bits: per-channel phase-restart pulse (key-on).
REQ-009 SHALL have port sync_all, input, 1 bit: restarts all channels.
REQ-010 SHALL have port speed, input, NUM_CH*DIV_W bits: per-channel divider; a larger value gives a slower LFO.
REQ-011 SHALL have port depth, input, NUM_CH*2 bits: per-channel depth 0..3.
REQ-012 SHALL have port mode, input, NUM_CH*2 bits: 0 triangle, 1 square, 2 ramp, 3 off.
REQ-013 SHALL have port offset_mul, output, NUM_CH*MUL_W bits: pitch-bend magnitude to the BFG.
REQ-014 SHALL have port offset_dir, output, NUM_CH bits: bend direction (0 up, 1 down).
REQ-015 SHALL have port cycle_done, output, NUM_CH bits: one-cycle pulse on full-cycle wrap.

Function
REQ-016 SHALL give each channel a div_cnt (DIV_W) and a phase (PHASE_W); channel c uses slice [c*W +: W] of each bus.
REQ-017 SHALL, on a clock edge with note_tick=1 and en[c]=1: if div_cnt >= speed then div_cnt<=0 and phase<=phase+1, else div_cnt<=div_cnt+1; each step therefore lasts speed+1 ticks.
REQ-018 SHALL, while en[c]=0, clear div_cnt and hold phase; outputs keep following the held phase.
REQ-019 SHALL, when trig[c]=1 or sync_all=1, load phase<=0 and div_cnt<=0; this has priority over a simultaneous note_tick.
REQ-020 SHALL let phase wrap from 2^PHASE_W-1 to 0 modulo; on that wrap edge cycle_done[c] pulses high for exactly the next clock cycle; a trig or sync_all restart SHALL NOT pulse cycle_done.
REQ-021 SHALL derive the following from phase: H=2^(PHASE_W-1); s=phase[PHASE_W-2:0]; dir=phase[PHASE_W-1].
REQ-022 SHALL compute the triangle shape tri=(s<H/2 ? s : H-1-s) >> (PHASE_W-2-MUL_W), giving 0..2^MUL_W-1 and back.
REQ-023 SHALL compute the ramp shape ramp = s >> (PHASE_W-1-MUL_W).
REQ-024 SHALL compute the square shape sq = 2^MUL_W-1 for the whole half-cycle.
REQ-025 SHALL scale the shape by depth: shape >> (3-depth), unsigned, no rounding.
REQ-026 SHALL, in mode 3, force offset_mul=0 and offset_dir=0; in all other modes offset_dir=dir.
REQ-027 SHALL register offset_mul and offset_dir, updating them from the current phase, depth and mode every clk50mhz edge; outputs change exactly one edge after phase changes.
REQ-028 SHALL apply depth/mode changes to the outputs on the next edge without disturbing phase.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously clear div_cnt, phase, offset_mul, offset_dir and cycle_done for all channels.
REQ-030 SHALL, after rst_n deassertion, start every channel at phase 0; a reset asserted mid-cycle discards all progress.

Structure
REQ-031 SHALL place the mode encodings (TRI, SQR, RAMP, OFF) and the default parameter values in shared package fx_pkg.
REQ-032 SHALL implement per-channel logic in sub-module fx_vibrato_lfo_ch, instantiated NUM_CH times by a generate loop; the top level only slices buses.

Verification
REQ-033 SHALL verify reset: assert rst_n=0 mid-operation -> all outputs 0 immediately (async), before any edge.
REQ-034 SHALL verify ch0 with en=1, speed=0, depth=3, mode=0 and note_tick every cycle -> offset_mul 0,1..7,7,6..0 with dir=0, then the same sequence with dir=1, then a cycle_done pulse after 32 steps.
REQ-035 SHALL verify speed=2 -> each offset_mul value held exactly 3 ticks; en=0 mid-step -> value frozen, div_cnt restarts on re-enable.
REQ-036 SHALL verify depth=1, mode=0 -> offset_mul per step 0,0,0,0,1,1,1,1,1,1,1,1,0,0,0,0; mode=1, depth=3 -> 7 constant with dir toggling every 16 steps.
REQ-037 SHALL verify trig[1] coincident with note_tick at phase 20 -> ch1 phase 0, offset_mul 0, dir 0, no cycle_done; ch0, ch2 and ch3 unaffected.
REQ-038 SHALL verify sync_all with four channels at different phases -> all channels restart together and match step-for-step thereafter.

Source files
------------

// File: rtl/fx_pkg.sv
// Shared definitions for the vibrato LFO block.
// Holds the waveform mode encodings and the default parameter values used
// by fx_vibrato_lfo and its per-channel sub-module fx_vibrato_lfo_ch.
package fx_pkg;

   // Waveform selection for the offset_mul/offset_dir generator.
   typedef enum logic [1:0] {
      MODE_TRI  = 2'd0,
      MODE_SQR  = 2'd1,
      MODE_RAMP = 2'd2,
      MODE_OFF  = 2'd3
   } fx_mode_e;

   localparam int unsigned DEF_NUM_CH  = 4;
   localparam int unsigned DEF_PHASE_W = 5;
   localparam int unsigned DEF_MUL_W   = 3;
   localparam int unsigned DEF_DIV_W   = 4;

endpackage : fx_pkg

// File: rtl/fx_vibrato_lfo_ch.sv
// One vibrato LFO channel: tick prescaler, phase accumulator, waveform shaper.
// Ports:
//   clk50mhz, rst_n      system clock, async active-low reset
//   note_tick            one-cycle step strobe
//   en, trig, sync_all   channel enable, key-on restart, global restart
//   speed [DIV_W]        prescaler; each phase step lasts speed+1 ticks
//   depth [2], mode [2]  output scaling and waveform select
//   offset_mul [MUL_W]   registered bend magnitude
//   offset_dir           registered bend direction (0 up, 1 down)
//   cycle_done           one-cycle pulse after a full-cycle phase wrap
module fx_vibrato_lfo_ch
   import fx_pkg::*;
#(
   parameter int unsigned PHASE_W = DEF_PHASE_W,
   parameter int unsigned MUL_W   = DEF_MUL_W,
   parameter int unsigned DIV_W   = DEF_DIV_W
) (
   input  logic               clk50mhz,
   input  logic               rst_n,
   input  logic               note_tick,
   input  logic               en,
   input  logic               trig,
   input  logic               sync_all,
   input  logic [DIV_W-1:0]   speed,
   input  logic [1:0]         depth,
   input  logic [1:0]         mode,
   output logic [MUL_W-1:0]   offset_mul,
   output logic               offset_dir,
   output logic               cycle_done
);

   localparam int unsigned HALF_W  = PHASE_W - 1;
   localparam int unsigned TRI_SH  = PHASE_W - 2 - MUL_W;
   localparam int unsigned RAMP_SH = PHASE_W - 1 - MUL_W;

   logic [DIV_W-1:0]   div_cnt;
   logic [PHASE_W-1:0] phase;

   logic [HALF_W-1:0]  s_c;
   logic [HALF_W-1:0]  fold_c;
   logic [MUL_W-1:0]   shape_c;
   logic [MUL_W-1:0]   mul_nxt_c;
   logic               dir_nxt_c;
   logic               step_c;

   // Prescaler and phase accumulator; restart wins over a coincident tick.
   assign step_c = note_tick && en && (div_cnt >= speed);

   always_ff @(posedge clk50mhz or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt    <= '0;
         phase      <= '0;
         cycle_done <= 1'b0;
      end else begin
         cycle_done <= 1'b0;
         if (trig || sync_all) begin
            div_cnt <= '0;
            phase   <= '0;
         end else if (!en) begin
            div_cnt <= '0;
         end else if (note_tick) begin
            if (step_c) begin
               div_cnt    <= '0;
               phase      <= phase + PHASE_W'(1);
               cycle_done <= &phase;
            end else begin
               div_cnt <= div_cnt + DIV_W'(1);
            end
         end
      end
   end

   // Within a half-cycle, s below H/2 is the rising leg; H-1-s equals ~s.
   assign s_c    = phase[HALF_W-1:0];
   assign fold_c = s_c[HALF_W-1] ? ~s_c : s_c;

   always_comb begin
      shape_c = '0;
      unique case (fx_mode_e'(mode))
         MODE_TRI:  shape_c = MUL_W'(fold_c >> TRI_SH);
         MODE_SQR:  shape_c = '1;
         MODE_RAMP: shape_c = MUL_W'(s_c >> RAMP_SH);
         MODE_OFF:  shape_c = '0;
      endcase
   end

   // Depth scaling: shift by 3-depth, which for a 2-bit depth is ~depth.
   always_comb begin
      mul_nxt_c = '0;
      dir_nxt_c = 1'b0;
      if (fx_mode_e'(mode) != MODE_OFF) begin
         mul_nxt_c = shape_c >> (~depth);
         dir_nxt_c = phase[PHASE_W-1];
      end
   end

   // Output registers follow the pre-edge phase, so they lag phase by one edge.
   always_ff @(posedge clk50mhz or negedge rst_n) begin
      if (!rst_n) begin
         offset_mul <= '0;
         offset_dir <= 1'b0;
      end else begin
         offset_mul <= mul_nxt_c;
         offset_dir <= dir_nxt_c;
      end
   end

endmodule : fx_vibrato_lfo_ch

// File: rtl/fx_vibrato_lfo.sv
// Multi-channel vibrato LFO feeding pitch-bend offsets to the BFG.
// Ports:
//   clk50mhz, rst_n            system clock, async active-low reset
//   note_tick                  one-cycle step strobe shared by all channels
//   en, trig [NUM_CH]          per-channel enable and key-on restart
//   sync_all                   restart every channel
//   speed [NUM_CH*DIV_W]       per-channel prescaler
//   depth, mode [NUM_CH*2]     per-channel scaling and waveform
//   offset_mul [NUM_CH*MUL_W]  per-channel bend magnitude
//   offset_dir, cycle_done     per-channel bend direction and wrap pulse
// Channel c uses slice [c*W +: W] of every bus. PHASE_W-2 >= MUL_W must hold.
module fx_vibrato_lfo
   import fx_pkg::*;
#(
   parameter int unsigned NUM_CH  = DEF_NUM_CH,
   parameter int unsigned PHASE_W = DEF_PHASE_W,
   parameter int unsigned MUL_W   = DEF_MUL_W,
   parameter int unsigned DIV_W   = DEF_DIV_W
) (
   input  logic                      clk50mhz,
   input  logic                      rst_n,
   input  logic                      note_tick,
   input  logic [NUM_CH-1:0]         en,
   input  logic [NUM_CH-1:0]         trig,
   input  logic                      sync_all,
   input  logic [NUM_CH*DIV_W-1:0]   speed,
   input  logic [NUM_CH*2-1:0]       depth,
   input  logic [NUM_CH*2-1:0]       mode,
   output logic [NUM_CH*MUL_W-1:0]   offset_mul,
   output logic [NUM_CH-1:0]         offset_dir,
   output logic [NUM_CH-1:0]         cycle_done
);

   // Bus slicing only; all behaviour lives in the channel module.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      fx_vibrato_lfo_ch #(
         .PHASE_W (PHASE_W),
         .MUL_W   (MUL_W),
         .DIV_W   (DIV_W)
      ) u_ch (
         .clk50mhz   (clk50mhz),
         .rst_n      (rst_n),
         .note_tick  (note_tick),
         .en         (en[c]),
         .trig       (trig[c]),
         .sync_all   (sync_all),
         .speed      (speed[c*DIV_W +: DIV_W]),
         .depth      (depth[c*2 +: 2]),
         .mode       (mode[c*2 +: 2]),
         .offset_mul (offset_mul[c*MUL_W +: MUL_W]),
         .offset_dir (offset_dir[c]),
         .cycle_done (cycle_done[c])
      );
   end

endmodule : fx_vibrato_lfo

// File: tb/tb_fx_vibrato_lfo.sv
// Scoreboard bench for fx_vibrato_lfo: a reference model predicts every
// clock edge's outputs into a queue, a monitor pops and compares them.
module tb_fx_vibrato_lfo;

   localparam int NUM_CH = 4;
   localparam int PW     = 5;
   localparam int MW     = 3;
   localparam int DW     = 4;

   logic                    clk50mhz  = 1'b0;
   logic                    rst_n     = 1'b0;
   logic                    note_tick = 1'b0;
   logic [NUM_CH-1:0]       en        = '0;
   logic [NUM_CH-1:0]       trig      = '0;
   logic                    sync_all  = 1'b0;
   logic [NUM_CH*DW-1:0]    speed     = '0;
   logic [NUM_CH*2-1:0]     depth     = '0;
   logic [NUM_CH*2-1:0]     mode      = '0;
   logic [NUM_CH*MW-1:0]    offset_mul;
   logic [NUM_CH-1:0]       offset_dir;
   logic [NUM_CH-1:0]       cycle_done;

   fx_vibrato_lfo #(
      .NUM_CH  (NUM_CH),
      .PHASE_W (PW),
      .MUL_W   (MW),
      .DIV_W   (DW)
   ) dut (
      .clk50mhz   (clk50mhz),
      .rst_n      (rst_n),
      .note_tick  (note_tick),
      .en         (en),
      .trig       (trig),
      .sync_all   (sync_all),
      .speed      (speed),
      .depth      (depth),
      .mode       (mode),
      .offset_mul (offset_mul),
      .offset_dir (offset_dir),
      .cycle_done (cycle_done)
   );

   always #10 clk50mhz = ~clk50mhz;

   typedef struct {
      logic [NUM_CH*MW-1:0] mul;
      logic [NUM_CH-1:0]    dir;
      logic [NUM_CH-1:0]    cd;
   } exp_t;

   exp_t sb[$];
   exp_t m_e;
   exp_t got;
   int   m_ph  [NUM_CH];
   int   m_cnt [NUM_CH];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Waveform value straight from the shape definitions, in plain integers.
   function automatic int f_mul(input int ph, input int dep, input int md);
      int h;
      int s;
      int shape;
      h = 1 << (PW - 1);
      s = ph % h;
      case (md)
         0:       shape = ((s < h / 2) ? s : h - 1 - s) / (1 << (PW - 2 - MW));
         1:       shape = (1 << MW) - 1;
         2:       shape = s / (1 << (PW - 1 - MW));
         default: return 0;
      endcase
      return shape / (1 << (3 - dep));
   endfunction

   // Reference model: predicts the outputs each edge will produce.
   always @(posedge clk50mhz) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            m_ph[c]  = 0;
            m_cnt[c] = 0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            int md;
            md = int'(mode[c*2 +: 2]);
            m_e.mul[c*MW +: MW] = MW'(f_mul(m_ph[c], int'(depth[c*2 +: 2]), md));
            m_e.dir[c] = (md != 3) && (m_ph[c] >= (1 << (PW - 1)));
            m_e.cd[c]  = 1'b0;
            if (trig[c] || sync_all) begin
               m_ph[c]  = 0;
               m_cnt[c] = 0;
            end else if (!en[c]) begin
               m_cnt[c] = 0;
            end else if (note_tick) begin
               if (m_cnt[c] >= int'(speed[c*DW +: DW])) begin
                  m_cnt[c] = 0;
                  if (m_ph[c] == (1 << PW) - 1) m_e.cd[c] = 1'b1;
                  m_ph[c] = (m_ph[c] + 1) % (1 << PW);
               end else begin
                  m_cnt[c] = m_cnt[c] + 1;
               end
            end
         end
         sb.push_back(m_e);
      end
   end

   // Monitor: compares DUT outputs against the queued prediction.
   always @(posedge clk50mhz) begin
      #1;
      if (!rst_n) begin
         check("reset_outputs", int'({offset_mul, offset_dir, cycle_done}), 0);
      end else if (sb.size() == 0) begin
         check("scoreboard_empty", 0, 1);
      end else begin
         got = sb.pop_front();
         check("offset_mul", int'(offset_mul), int'(got.mul));
         check("offset_dir", int'(offset_dir), int'(got.dir));
         check("cycle_done", int'(cycle_done), int'(got.cd));
      end
   end

   int tri_tab [16] = '{0,1,2,3,4,5,6,7,7,6,5,4,3,2,1,0};
   int dep1_tab[16] = '{0,0,0,0,1,1,1,1,1,1,1,1,0,0,0,0};

   initial begin
      repeat (3) @(negedge clk50mhz);
      rst_n = 1'b1;

      // ch0 triangle, full depth, step every tick: two full cycles.
      en[0] = 1'b1; speed[3:0] = 4'd0; depth[1:0] = 2'd3; mode[1:0] = 2'd0;
      note_tick = 1'b1;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk50mhz);
         check("tri_seq_mul", int'(offset_mul[2:0]), tri_tab[i % 16]);
         check("tri_seq_dir", int'(offset_dir[0]), ((i % 32) >= 16) ? 1 : 0);
         check("tri_seq_cd", int'(cycle_done[0]), (i == 31 || i == 63) ? 1 : 0);
      end

      // depth 1 triangle after a global restart.
      depth[1:0] = 2'd1;
      sync_all = 1'b1;
      @(negedge clk50mhz);
      sync_all = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk50mhz);
         check("depth1_mul", int'(offset_mul[2:0]), dep1_tab[i]);
      end

      // square, full depth.
      mode[1:0] = 2'd1; depth[1:0] = 2'd3;
      repeat (40) @(negedge clk50mhz);

      // speed 2 with an enable drop mid-step.
      mode[1:0] = 2'd0; speed[3:0] = 4'd2;
      repeat (31) @(negedge clk50mhz);
      en[0] = 1'b0;
      repeat (5) @(negedge clk50mhz);
      en[0] = 1'b1;
      repeat (20) @(negedge clk50mhz);

      // trig[1] coincident with a tick at phase 20.
      en = '1; speed = '0; depth = '1; mode = '0;
      sync_all = 1'b1;
      @(negedge clk50mhz);
      sync_all = 1'b0;
      repeat (20) @(negedge clk50mhz);
      trig = 4'b0010;
      @(negedge clk50mhz);
      trig = '0;
      @(negedge clk50mhz);
      check("trig_ch1_mul", int'(offset_mul[5:3]), 0);
      check("trig_ch1_dir", int'(offset_dir[1]), 0);
      check("trig_ch1_cd", int'(cycle_done[1]), 0);
      check("trig_ch0_mul", int'(offset_mul[2:0]), 5);
      check("trig_ch0_dir", int'(offset_dir[0]), 1);
      check("trig_ch3_mul", int'(offset_mul[11:9]), 5);

      // channels diverge, then sync_all realigns them.
      speed = {4'd3, 4'd2, 4'd1, 4'd0};
      repeat (37) @(negedge clk50mhz);
      sync_all = 1'b1;
      speed = {4'd1, 4'd1, 4'd1, 4'd1};
      @(negedge clk50mhz);
      sync_all = 1'b0;
      repeat (50) @(negedge clk50mhz);

      // randomized operation.
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk50mhz);
         note_tick = ($urandom_range(0, 2) != 0);
         for (int c = 0; c < NUM_CH; c++) begin
            if ($urandom_range(0, 15) == 0) en[c] = ~en[c];
            trig[c] = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 40) == 0) speed[c*DW +: DW] = DW'($urandom_range(0, 3));
            if ($urandom_range(0, 30) == 0) depth[c*2 +: 2] = 2'($urandom);
            if ($urandom_range(0, 50) == 0) mode[c*2 +: 2] = 2'($urandom);
         end
         sync_all = ($urandom_range(0, 200) == 0);
      end
      trig = '0; sync_all = 1'b0;
      en = '1; mode = '0; depth = '1; speed = '0; note_tick = 1'b1;
      repeat (10) @(negedge clk50mhz);

      // asynchronous reset mid-cycle.
      #3;
      rst_n = 1'b0;
      #1;
      check("async_reset_mul", int'(offset_mul), 0);
      check("async_reset_dir", int'(offset_dir), 0);
      check("async_reset_cd", int'(cycle_done), 0);
      repeat (2) @(negedge clk50mhz);
      rst_n = 1'b1;
      repeat (40) @(negedge clk50mhz);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule : tb_fx_vibrato_lfo
